led_breath_driver: RTL and testbench
====================================

// Module: led_breath_driver
// PURPOSE
//  Downstream of the LED blinker. Consumes its 1-bit toggling status line and
//  drives one board LED with an 8-bit PWM "breathing" fade instead of a hard on/off.
//  A rising status edge fades the LED up. A falling edge fades it down.
//  Sits between the blinker output and the LED pin, in the same 50 MHz domain.
// PARAMETERS
//  PWM_BITS  8        brightness/PWM resolution; MAX = 2**PWM_BITS-1
//  RAMP_DIV  195_312  clock cycles per brightness step (~1 s full ramp at 50 MHz)
// PORTS
//  clock     in   1         system clock, all logic on posedge
//  reset_n   in   1         asynchronous, active-low reset
//  blink_in  in   1         toggle line from blinker; treated as asynchronous
//  enable    in   1         0 forces LED dark; the FSM keeps running
//  led_out   out  1         registered PWM drive to LED pin
//  level     out  PWM_BITS  current brightness, 0..MAX
//  ramp_busy out  1         1 while in RAMP_UP or RAMP_DOWN
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert not required):
//   - State = IDLE_OFF.
//   - led_out=0, level=0, ramp_busy=0.
//   - Sync flops, edge register, step timer and pwm_cnt all cleared to 0.
//  Input path:
//   - 2-flop synchroniser on blink_in, then a 1-flop delayed copy.
//   - rise_ev = s & ~d; fall_ev = ~s & d.
//   - Latency from blink_in change to event pulse: 3 clocks. Each pulse lasts 1 cycle.
//   - blink_in=1 at reset release yields rise_ev on cycle 3 (intended: LED fades on).
//  FSM states: IDLE_OFF, RAMP_UP, IDLE_ON, RAMP_DOWN.
//   - rise_ev: IDLE_OFF/RAMP_DOWN -> RAMP_UP. Ignored in RAMP_UP/IDLE_ON.
//   - fall_ev: IDLE_ON/RAMP_UP -> RAMP_DOWN. Ignored in RAMP_DOWN/IDLE_OFF.
//   - A reversal keeps the current level (no jump); the ramp continues from it.
//  Step timer:
//   - Counts 0..RAMP_DIV-1 while ramp_busy, then wraps.
//   - Held at 0 in the IDLE states.
//   - Cleared to 0 on any accepted event.
//   - Terminal count in RAMP_UP: level+1. On reaching MAX -> IDLE_ON.
//   - Terminal count in RAMP_DOWN: level-1. On reaching 0 -> IDLE_OFF.
//   - level saturates; never wraps past 0 or MAX.
//   - Event and terminal count in the same cycle: the event wins, level is unchanged
//     that cycle, and the timer is cleared.
//  PWM:
//   - pwm_cnt free-runs 0..MAX and wraps; it is unaffected by the FSM.
//   - led_out <= enable & ((level==MAX) | (pwm_cnt < level)).
//   - level=0: always dark. level=MAX: solid on. Otherwise high for exactly `level`
//     of every 2**PWM_BITS cycles.
//   - led_out is 1 cycle behind the compare.
//   - enable falling forces led_out=0 on the next edge. level and the FSM are unaffected.
//  ramp_busy is combinational from the state register (glitch-free, single source).
// TESTING  (RAMP_DIV=4, PWM_BITS=8 for simulation)
//  1. reset_n=0, blink_in=1, clock running
//     -> led_out=0, level=0, ramp_busy=0.
//     Release reset -> ramp_busy=1 on clock 3, level=1 at clock 3+4.
//  2. blink_in 0->1 from IDLE_OFF
//     -> level steps +1 every 4 clocks, reaches 255 after 1020 clocks.
//     -> ramp_busy drops in the same cycle; led_out held 1.
//  3. blink_in 1->0 when level=100 in RAMP_UP
//     -> RAMP_DOWN, level never exceeds 100, reaches 0 after 400 clocks, IDLE_OFF.
//  4. Hold level=64 (stop clocking events at IDLE, or force RAMP_DIV large)
//     -> led_out high exactly 64 of every 256 cycles.
//     -> level=0 gives 0/256; level=255 gives 256/256.
//  5. enable 1->0 mid RAMP_UP
//     -> led_out=0 next edge, level keeps incrementing.
//     enable 0->1 -> PWM resumes at the current level.
//  6. reset_n asserted mid RAMP_DOWN between clock edges
//     -> level, led_out, ramp_busy go 0 immediately (no clock edge needed).
//  7. Event on the exact terminal-count cycle -> level unchanged, timer restarts at 0.

Source files
------------

// File: rtl/led_breath_driver.sv
// PWM "breathing" LED driver: fades one LED up or down on edges of the blinker status line.
// Brightness steps once every RAMP_DIV clocks. PWM duty equals level / 2**PWM_BITS.
module led_breath_driver #(
    parameter int PWM_BITS = 8,
    parameter int RAMP_DIV = 195_312
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                blink_in,
    input  logic                enable,
    output logic                led_out,
    output logic [PWM_BITS-1:0] level,
    output logic                ramp_busy
);

    localparam int SYNC_STAGES = 2;
    localparam int TIMER_W     = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = '1;
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(RAMP_DIV - 1);

    typedef enum logic [1:0] {
        IDLE_OFF  = 2'd0,
        RAMP_UP   = 2'd1,
        IDLE_ON   = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t                state_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                  delay_reg;
    logic [TIMER_W-1:0]    timer_reg;
    logic [PWM_BITS-1:0]   level_reg;
    logic [PWM_BITS-1:0]   pwm_cnt_reg;
    logic                  led_out_reg;

    logic sync_s;
    logic rise_ev;
    logic fall_ev;
    logic accept_up;
    logic accept_down;
    logic terminal;

    // blink_in is asynchronous to clock: two flops before anything looks at it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], blink_in};
            delay_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_s      = sync_reg[SYNC_STAGES-1];
    assign rise_ev     = sync_s & ~delay_reg;
    assign fall_ev     = ~sync_s & delay_reg;
    assign accept_up   = rise_ev & ((state_reg == IDLE_OFF) | (state_reg == RAMP_DOWN));
    assign accept_down = fall_ev & ((state_reg == IDLE_ON) | (state_reg == RAMP_UP));
    assign terminal    = (timer_reg == TIMER_LAST);

    // Accepted events take priority over a coincident terminal count: level holds, timer restarts.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE_OFF;
            level_reg <= '0;
            timer_reg <= '0;
        end else if (accept_up) begin
            state_reg <= RAMP_UP;
            timer_reg <= '0;
        end else if (accept_down) begin
            state_reg <= RAMP_DOWN;
            timer_reg <= '0;
        end else begin
            case (state_reg)
                RAMP_UP: begin
                    if (terminal) begin
                        timer_reg <= '0;
                        if (level_reg != LEVEL_MAX) begin
                            level_reg <= level_reg + 1'b1;
                        end
                        if (level_reg >= LEVEL_MAX - 1'b1) begin
                            state_reg <= IDLE_ON;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (terminal) begin
                        timer_reg <= '0;
                        if (level_reg != '0) begin
                            level_reg <= level_reg - 1'b1;
                        end
                        if (level_reg <= PWM_BITS'(1)) begin
                            state_reg <= IDLE_OFF;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    timer_reg <= '0;
                end
            endcase
        end
    end

    // PWM counter free-runs independent of the FSM; full scale is forced solid on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_reg <= '0;
            led_out_reg <= 1'b0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            led_out_reg <= enable & ((level_reg == LEVEL_MAX) | (pwm_cnt_reg < level_reg));
        end
    end

    assign ramp_busy = (state_reg == RAMP_UP) | (state_reg == RAMP_DOWN);
    assign level     = level_reg;
    assign led_out   = led_out_reg;

endmodule

// File: tb/tb_led_breath_driver.sv
// Self-checking bench for led_breath_driver: directed scenarios plus random toggling,
// every cycle compared against a direction/level/elapsed-time model of the fade behaviour.
module tb_led_breath_driver;

    localparam int PWM_BITS = 8;
    localparam int RAMP_DIV = 4;
    localparam int MAX      = (1 << PWM_BITS) - 1;

    logic                clock    = 1'b0;
    logic                reset_n  = 1'b0;
    logic                blink_in = 1'b0;
    logic                enable   = 1'b1;
    logic                led_out;
    logic [PWM_BITS-1:0] level;
    logic                ramp_busy;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int lvl_m;
    int phase_m;
    int elapsed_m;
    bit dir_m;
    bit busy_m;
    bit led_m;
    bit hist_q[$];

    always #5 clock = ~clock;

    led_breath_driver #(.PWM_BITS(PWM_BITS), .RAMP_DIV(RAMP_DIV)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .blink_in (blink_in),
        .enable   (enable),
        .led_out  (led_out),
        .level    (level),
        .ramp_busy(ramp_busy)
    );

    // Model: blink samples seen by the fade logic lag by two clocks; an edge in the opposite
    // direction to the current target retargets; every RAMP_DIV clocks level moves one step.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lvl_m = 0; phase_m = 0; elapsed_m = 0;
            dir_m = 0; busy_m = 0; led_m = 0;
            hist_q = '{0, 0, 0};
        end else begin
            bit rise, fall;
            rise = hist_q[1] & ~hist_q[0];
            fall = ~hist_q[1] & hist_q[0];
            led_m   = enable && (lvl_m == MAX || phase_m < lvl_m);
            phase_m = (phase_m + 1) % (MAX + 1);
            if ((rise && !dir_m) || (fall && dir_m)) begin
                dir_m = rise; busy_m = 1; elapsed_m = 0;
            end else if (busy_m) begin
                elapsed_m++;
                if (elapsed_m == RAMP_DIV) begin
                    elapsed_m = 0;
                    lvl_m = dir_m ? ((lvl_m < MAX) ? lvl_m + 1 : MAX) : ((lvl_m > 0) ? lvl_m - 1 : 0);
                    if (lvl_m == (dir_m ? MAX : 0)) busy_m = 0;
                end
            end
            hist_q.push_back(blink_in);
            void'(hist_q.pop_front());
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check("led_out", {31'd0, led_out}, {31'd0, led_m});
        check("level", {24'd0, level}, lvl_m);
        check("ramp_busy", {31'd0, ramp_busy}, {31'd0, busy_m});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input bit blink_val);
        reset_n  = 1'b0;
        blink_in = blink_val;
        enable   = 1'b1;
        repeat (3) @(negedge clock);
        check("rst_led", {31'd0, led_out}, 0);
        check("rst_level", {24'd0, level}, 0);
        check("rst_busy", {31'd0, ramp_busy}, 0);
        reset_n = 1'b1;
    endtask

    initial begin
        int cnt;
        int mx;

        // Reset with blink high, then fade up the whole way.
        do_reset(1'b1);
        ticks(2);
        check("t1_busy_c2", {31'd0, ramp_busy}, 0);
        tick();
        check("t1_busy_c3", {31'd0, ramp_busy}, 1);
        ticks(3);
        check("t1_level_c6", {24'd0, level}, 0);
        tick();
        check("t1_level_c7", {24'd0, level}, 1);
        ticks(1015);
        check("t2_level_c1022", {24'd0, level}, 254);
        check("t2_busy_c1022", {31'd0, ramp_busy}, 1);
        tick();
        check("t2_level_c1023", {24'd0, level}, MAX);
        check("t2_busy_c1023", {31'd0, ramp_busy}, 0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            cnt += led_out;
        end
        check("t4_duty_max", cnt, 256);

        // Fade up to 100, reverse, fade down to 0.
        do_reset(1'b0);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            cnt += led_out;
        end
        check("t4_duty_zero", cnt, 0);
        blink_in = 1'b1;
        cnt = 0;
        while (level !== 8'd100 && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("t3_reach100", {24'd0, level}, 100);
        blink_in = 1'b0;
        cnt = 0;
        mx = 0;
        do begin
            tick();
            cnt++;
            if (int'(level) > mx) mx = int'(level);
        end while (!(level == 0 && !ramp_busy) && cnt < 1000);
        check("t3_down_cycles", cnt, 403);
        check("t3_never_above_100", {31'd0, (mx <= 100)}, 1);

        // Reversal landing exactly on a terminal count.
        do_reset(1'b1);
        ticks(8);
        blink_in = 1'b0;
        ticks(2);
        check("t7_level_c10", {24'd0, level}, 1);
        tick();
        check("t7_level_c11", {24'd0, level}, 1);
        check("t7_busy_c11", {31'd0, ramp_busy}, 1);
        ticks(3);
        check("t7_level_c14", {24'd0, level}, 1);
        tick();
        check("t7_level_c15", {24'd0, level}, 0);
        check("t7_busy_c15", {31'd0, ramp_busy}, 0);

        // Enable drop mid ramp: LED dark, level keeps climbing.
        do_reset(1'b1);
        ticks(20);
        enable = 1'b0;
        tick();
        check("t5_led_off", {31'd0, led_out}, 0);
        check("t5_level_c21", {24'd0, level}, 4);
        ticks(40);
        check("t5_level_c61", {24'd0, level}, 14);
        check("t5_led_still_off", {31'd0, led_out}, 0);
        enable = 1'b1;
        ticks(300);

        // Asynchronous reset between edges while fading down.
        blink_in = 1'b0;
        ticks(60);
        check("t6_pre_busy", {31'd0, ramp_busy}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_level", {24'd0, level}, 0);
        check("t6_async_led", {31'd0, led_out}, 0);
        check("t6_async_busy", {31'd0, ramp_busy}, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Random toggling of blink_in and enable.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) blink_in = ~blink_in;
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
